// File: rtl/encode_modrm_sib.sv
// 80386 32-bit memory operand encoder: {base,index,scale,disp,reg} -> ModR/M, optional SIB, 0/1/4 disp bytes.
// ModR/M appears the cycle after acceptance; each byte holds until out_ready, one request in flight at a time.
module encode_modrm_sib #(
  parameter bit SHORT_DISP_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_reg,
  input  logic        req_base_en,
  input  logic [2:0]  req_base,
  input  logic        req_index_en,
  input  logic [2:0]  req_index,
  input  logic [1:0]  req_scale,
  input  logic [31:0] req_disp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_MODRM, S_SIB, S_DISP, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        alive_q;
  logic [7:0]  modrm_q, modrm_d;
  logic [7:0]  sib_q, sib_d;
  logic [31:0] disp_q, disp_d;
  logic        has_sib_q, has_sib_d;
  logic        has_disp_q, has_disp_d;
  logic [1:0]  dlast_q, dlast_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        illegal;
  logic        disp_zero;
  logic        disp_short;
  logic        f_use_sib;
  logic        f_has_disp;
  logic [1:0]  f_mod;
  logic [1:0]  f_dlast;
  logic [2:0]  f_rm;
  logic [7:0]  f_sib;

  // Form selection from the live request; only sampled on acceptance.
  always_comb begin
    illegal    = req_index_en && (req_index == 3'b100);
    disp_zero  = (req_disp == 32'd0);
    disp_short = SHORT_DISP_EN && ((&req_disp[31:7]) || !(|req_disp[31:7]));
    f_use_sib  = 1'b0;
    f_has_disp = 1'b0;
    f_mod      = 2'b00;
    f_dlast    = 2'd0;
    f_rm       = req_base;
    f_sib      = 8'h00;
    if (!req_base_en) begin
      // Absolute or index-only: mod=00 with rm/SIB-base 101 means disp32 with no base.
      f_use_sib  = req_index_en;
      f_rm       = req_index_en ? 3'b100 : 3'b101;
      f_sib      = {req_scale, req_index, 3'b101};
      f_has_disp = 1'b1;
      f_dlast    = 2'd3;
    end else begin
      f_use_sib = req_index_en || (req_base == 3'b100);
      f_rm      = f_use_sib ? 3'b100 : req_base;
      f_sib     = {req_index_en ? req_scale : 2'b00,
                   req_index_en ? req_index : 3'b100,
                   req_base};
      if (disp_zero && (req_base != 3'b101)) begin
        f_mod = 2'b00;
      end else if (disp_zero || disp_short) begin
        // EBP base cannot use mod=00, so a zero disp still needs a disp8.
        f_mod      = 2'b01;
        f_has_disp = 1'b1;
        f_dlast    = 2'd0;
      end else begin
        f_mod      = 2'b10;
        f_has_disp = 1'b1;
        f_dlast    = 2'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    modrm_d    = modrm_q;
    sib_d      = sib_q;
    disp_d     = disp_q;
    has_sib_d  = has_sib_q;
    has_disp_d = has_disp_q;
    dlast_d    = dlast_q;
    cnt_d      = cnt_q;
    req_ready  = (state_q == S_IDLE) && alive_q;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (illegal) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_MODRM;
            modrm_d    = {f_mod, req_reg, f_rm};
            sib_d      = f_sib;
            disp_d     = req_disp;
            has_sib_d  = f_use_sib;
            has_disp_d = f_has_disp;
            dlast_d    = f_dlast;
            cnt_d      = 2'd0;
          end
        end
      end
      S_MODRM: begin
        out_valid = 1'b1;
        out_data  = modrm_q;
        out_last  = !has_sib_q && !has_disp_q;
        if (out_ready) begin
          state_d = has_sib_q ? S_SIB : (has_disp_q ? S_DISP : S_IDLE);
        end
      end
      S_SIB: begin
        out_valid = 1'b1;
        out_data  = sib_q;
        out_last  = !has_disp_q;
        if (out_ready) begin
          state_d = has_disp_q ? S_DISP : S_IDLE;
        end
      end
      S_DISP: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == dlast_q);
        case (cnt_q)
          2'd0:    out_data = disp_q[7:0];
          2'd1:    out_data = disp_q[15:8];
          2'd2:    out_data = disp_q[23:16];
          default: out_data = disp_q[31:24];
        endcase
        if (out_ready) begin
          if (out_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      alive_q    <= 1'b0;
      modrm_q    <= 8'h00;
      sib_q      <= 8'h00;
      disp_q     <= 32'd0;
      has_sib_q  <= 1'b0;
      has_disp_q <= 1'b0;
      dlast_q    <= 2'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      modrm_q    <= modrm_d;
      sib_q      <= sib_d;
      disp_q     <= disp_d;
      has_sib_q  <= has_sib_d;
      has_disp_q <= has_disp_d;
      dlast_q    <= dlast_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_encode_modrm_sib.sv
// Directed table-driven bench for encode_modrm_sib, both disp8 policies, plus backpressure and reset sequences.
module tb_encode_modrm_sib;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  req_reg = '0;
  logic        req_base_en = 1'b0;
  logic [2:0]  req_base = '0;
  logic        req_index_en = 1'b0;
  logic [2:0]  req_index = '0;
  logic [1:0]  req_scale = '0;
  logic [31:0] req_disp = '0;
  logic        out_ready = 1'b0;

  logic       rdy_a, vld_a, last_a, err_a;
  logic       rdy_b, vld_b, last_b, err_b;
  logic [7:0] dat_a, dat_b;
  logic       rdy, vld, last, err;
  logic [7:0] dat;

  always #5 clock = ~clock;

  encode_modrm_sib #(.SHORT_DISP_EN(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid && !sel), .req_ready(rdy_a),
    .req_reg(req_reg), .req_base_en(req_base_en), .req_base(req_base),
    .req_index_en(req_index_en), .req_index(req_index), .req_scale(req_scale),
    .req_disp(req_disp),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a), .out_last(last_a), .err(err_a)
  );

  encode_modrm_sib #(.SHORT_DISP_EN(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid && sel), .req_ready(rdy_b),
    .req_reg(req_reg), .req_base_en(req_base_en), .req_base(req_base),
    .req_index_en(req_index_en), .req_index(req_index), .req_scale(req_scale),
    .req_disp(req_disp),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b), .out_last(last_b), .err(err_b)
  );

  assign rdy  = sel ? rdy_b  : rdy_a;
  assign vld  = sel ? vld_b  : vld_a;
  assign dat  = sel ? dat_b  : dat_a;
  assign last = sel ? last_b : last_a;
  assign err  = sel ? err_b  : err_a;

  typedef struct {
    bit          sel;
    logic [2:0]  rg;
    logic        be;
    logic [2:0]  base;
    logic        ie;
    logic [2:0]  idx;
    logic [1:0]  scale;
    logic [31:0] disp;
    bit          bad;
    int          len;
    logic [55:0] bytes;  // expected stream, first byte in bits [7:0]
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit s, logic [2:0] rg, logic be, logic [2:0] base, logic ie,
                              logic [2:0] idx, logic [1:0] scale, logic [31:0] disp,
                              bit bad, int len, logic [55:0] bytes);
    vec_t v;
    v.sel = s; v.rg = rg; v.be = be; v.base = base; v.ie = ie; v.idx = idx;
    v.scale = scale; v.disp = disp; v.bad = bad; v.len = len; v.bytes = bytes;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for req_ready, presents one request for one cycle, then scrambles the inputs.
  task automatic send(vec_t v);
    int t = 0;
    @(negedge clock);
    sel = v.sel;
    #1;
    while (!rdy && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("ready_before_req", {31'd0, rdy}, 32'd1);
    req_reg = v.rg; req_base_en = v.be; req_base = v.base;
    req_index_en = v.ie; req_index = v.idx; req_scale = v.scale; req_disp = v.disp;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    req_reg = ~req_reg; req_base = ~req_base; req_base_en = ~req_base_en;
    req_index = $urandom_range(0, 3); req_scale = ~req_scale; req_disp = $urandom;
  endtask

  // Called on the negedge one cycle after acceptance; optionally holds out_ready low
  // for stall_n cycles while byte stall_k is presented.
  task automatic collect(vec_t v, int stall_k, int stall_n);
    int  k = 0;
    int  cyc = 0;
    int  stalls = stall_n;
    bit  done = 1'b0;
    chk("first_byte_latency", {31'd0, vld}, 32'd1);
    while (!done && cyc < 40) begin
      if (vld) begin
        chk("byte", {24'd0, dat}, {24'd0, v.bytes[8*(k < 7 ? k : 6) +: 8]});
        chk("last", {31'd0, last}, {31'd0, k == v.len - 1});
        if (k == stall_k && stalls > 0) begin
          out_ready = 1'b0;
          stalls--;
        end else begin
          out_ready = 1'b1;
          if (last) done = 1'b1;
          k++;
        end
      end else begin
        chk("valid_dropped", {31'd0, vld}, 32'd1);
        out_ready = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    if (!done) chk("stream_timeout", 32'd0, 32'd1);
    chk("length", k, v.len);
    chk("idle_valid", {31'd0, vld}, 32'd0);
    chk("idle_ready", {31'd0, rdy}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run(vec_t v);
    send(v);
    if (v.bad) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_no_valid", {31'd0, vld}, 32'd0);
      chk("err_not_ready", {31'd0, rdy}, 32'd0);
      @(negedge clock);
      chk("err_cleared", {31'd0, err}, 32'd0);
      chk("err_no_valid2", {31'd0, vld}, 32'd0);
      chk("err_ready_back", {31'd0, rdy}, 32'd1);
    end else begin
      collect(v, -1, 0);
    end
  endtask

  initial begin
    vec_t v4;
    vec_t v1;
    // sel rg be base ie idx sc disp bad len bytes
    vecs.push_back(mk(0, 3'b010, 1, 3'd0, 0, 3'd0, 2'd0, 32'h0,        0, 1, 56'h10));
    vecs.push_back(mk(0, 3'b000, 1, 3'd5, 0, 3'd0, 2'd0, 32'h0,        0, 2, 56'h00_45));
    vecs.push_back(mk(0, 3'b000, 1, 3'd4, 0, 3'd0, 2'd0, 32'h10,       0, 3, 56'h10_24_44));
    vecs.push_back(mk(1, 3'b000, 1, 3'd4, 0, 3'd0, 2'd0, 32'h10,       0, 6, 56'h00_00_00_10_24_84));
    vecs.push_back(mk(0, 3'b000, 0, 3'd0, 1, 3'd1, 2'd2, 32'h12345678, 0, 6, 56'h12_34_56_78_8D_04));
    vecs.push_back(mk(0, 3'b000, 1, 3'd3, 1, 3'd1, 2'd2, 32'hFFFFFF80, 0, 3, 56'h80_8B_44));
    vecs.push_back(mk(0, 3'b000, 1, 3'd0, 1, 3'd4, 2'd0, 32'h0,        1, 0, 56'h0));
    vecs.push_back(mk(0, 3'b111, 0, 3'd0, 0, 3'd0, 2'd0, 32'h4,        0, 5, 56'h00_00_00_04_3D));
    vecs.push_back(mk(0, 3'b000, 0, 3'd0, 0, 3'd0, 2'd0, 32'h0,        0, 5, 56'h00_00_00_00_05));
    vecs.push_back(mk(0, 3'b001, 1, 3'd6, 0, 3'd0, 2'd0, 32'h7F,       0, 2, 56'h7F_4E));
    vecs.push_back(mk(0, 3'b000, 1, 3'd7, 0, 3'd0, 2'd0, 32'h80,       0, 5, 56'h00_00_00_80_87));
    vecs.push_back(mk(0, 3'b000, 1, 3'd0, 0, 3'd0, 2'd0, 32'hFFFFFF7F, 0, 5, 56'hFF_FF_FF_7F_80));
    vecs.push_back(mk(0, 3'b011, 1, 3'd5, 1, 3'd0, 2'd3, 32'h0,        0, 3, 56'h00_C5_5C));
    vecs.push_back(mk(0, 3'b100, 1, 3'd2, 1, 3'd6, 2'd1, 32'h0,        0, 2, 56'h72_24));
    vecs.push_back(mk(0, 3'b000, 1, 3'd4, 0, 3'd4, 2'd3, 32'h0,        0, 2, 56'h24_04));
    vecs.push_back(mk(1, 3'b000, 1, 3'd5, 0, 3'd0, 2'd0, 32'h0,        0, 2, 56'h00_45));
    vecs.push_back(mk(1, 3'b001, 1, 3'd6, 0, 3'd0, 2'd0, 32'h7F,       0, 5, 56'h00_00_00_7F_8E));
    v1 = vecs[0];
    v4 = vecs[4];

    // Reset values on both instances.
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd0);
    chk("rst_ready_b", {31'd0, rdy_b}, 32'd0);
    chk("rst_valid",   {31'd0, vld_a | vld_b}, 32'd0);
    chk("rst_data",    {24'd0, dat_a | dat_b}, 32'd0);
    chk("rst_last",    {31'd0, last_a | last_b}, 32'd0);
    chk("rst_err",     {31'd0, err_a | err_b}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst_a", {31'd0, rdy_a}, 32'd1);
    chk("ready_after_rst_b", {31'd0, rdy_b}, 32'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Backpressure on 0x56: held three cycles with no loss or duplication.
    send(v4);
    collect(v4, 3, 3);

    // Reset in the middle of a stream, then a fresh request.
    send(v4);
    chk("mid_byte0", {24'd0, dat}, 32'h04);
    out_ready = 1'b1;
    @(negedge clock);
    chk("mid_byte1", {24'd0, dat}, 32'h8D);
    @(negedge clock);
    out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, vld}, 32'd0);
    chk("mid_rst_data",  {24'd0, dat}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_rst_ready_back", {31'd0, rdy}, 32'd1);
    run(v1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
